// File: rtl/axis_reg_slice_pkg.sv
// Shared definitions for the AXI-Stream register slice: mode encodings and
// the FULL-mode occupancy states.
package axis_reg_slice_pkg;

  localparam int MODE_FULL = 0;
  localparam int MODE_FWD  = 1;
  localparam int MODE_BWD  = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } full_state_e;

  // State encoding doubles as the number of held beats.
  function automatic logic [1:0] state_level(input full_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// AXI-Stream register slice: FULL (valid+ready registered), FWD (valid/data
// registered) or BWD (ready registered, skid buffer). Unknown MODE -> FULL.
module axis_reg_slice
  import axis_reg_slice_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MODE   = MODE_FULL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        level
);

  if (MODE == MODE_FWD) begin : g_fwd
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign s_ready = !valid_q || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (s_valid && s_ready) begin
        valid_q <= 1'b1;
        data_q  <= s_data;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign level   = {1'b0, valid_q};

  end else if (MODE == MODE_BWD) begin : g_bwd
    logic              ready_q;
    logic              skid_valid_q;
    logic              skid_valid_n;
    logic              push;
    logic              skid_load;
    logic [DATA_W-1:0] skid_q;

    // ready_q tracks !skid_valid once out of reset; gating the pass-through
    // with it keeps m_valid low during reset and the first cycle after it.
    assign push      = s_valid && ready_q;
    assign skid_load = push && !m_ready;

    always_comb begin
      skid_valid_n = skid_valid_q;
      if (skid_load)
        skid_valid_n = 1'b1;
      else if (skid_valid_q && m_ready)
        skid_valid_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ready_q      <= 1'b0;
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
      end else begin
        ready_q      <= !skid_valid_n;
        skid_valid_q <= skid_valid_n;
        if (skid_load)
          skid_q <= s_data;
      end
    end

    assign s_ready = ready_q;
    assign m_valid = skid_valid_q || push;
    assign m_data  = skid_valid_q ? skid_q : (push ? s_data : '0);
    assign level   = {1'b0, skid_valid_q};

  end else begin : g_full
    full_state_e       state_q;
    full_state_e       state_n;
    logic              ready_q;
    logic              push;
    logic              pop;
    logic              main_from_s;
    logic              main_from_skid;
    logic              skid_load;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign push = s_valid && ready_q;
    assign pop  = (state_q != ST_EMPTY) && m_ready;

    always_comb begin
      state_n        = state_q;
      main_from_s    = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
        ST_EMPTY: if (push) begin
          state_n     = ST_ONE;
          main_from_s = 1'b1;
        end
        ST_ONE: begin
          if (push && pop) begin
            main_from_s = 1'b1;
          end else if (push) begin
            state_n   = ST_TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          state_n        = ST_ONE;
          main_from_skid = 1'b1;
        end
        default: state_n = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_n;
        ready_q <= (state_n != ST_TWO);
        if (main_from_s)
          main_q <= s_data;
        else if (main_from_skid)
          main_q <= skid_q;
        if (skid_load)
          skid_q <= s_data;
      end
    end

    assign s_ready = ready_q;
    assign m_valid = (state_q != ST_EMPTY);
    assign m_data  = main_q;
    assign level   = state_level(state_q);
  end

endmodule
